// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle stage sequencer for the SEQ processor.
// Build option: define SEQ_SKIP_MEM_EN to bypass MEMORY for non-memory icodes.
module seq_stage_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             cc_we,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [1:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DEC   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_MEM   = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;
    localparam logic [2:0] S_PCUPD = 3'd6;
    localparam logic [2:0] S_HALT  = 3'd7;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       stat_q, stat_d;
    logic [3:0]       icode_q, icode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       wait_q, wait_d;
    logic             cnt_inc;
    logic             mem_class;

    // Loads, stores, calls, returns and push/pop really touch data memory
    always_comb begin
        mem_class = (icode_q == 4'h4) || (icode_q == 4'h5) ||
                    (icode_q == 4'h8) || (icode_q == 4'h9) ||
                    (icode_q == 4'hA) || (icode_q == 4'hB);
    end

    // Next-state, status and wait-counter logic
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        icode_d = icode_q;
        wait_d  = wait_q;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else if (!instr_valid || icode > 4'hB) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALT;
                end else if (icode == 4'h0) begin
                    stat_d  = STAT_HLT;
                    cnt_inc = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_DEC;
                end
            end
            S_DEC: state_d = S_EXEC;
            S_EXEC: begin
                wait_d = 8'd0;
`ifdef SEQ_SKIP_MEM_EN
                state_d = mem_class ? S_MEM : S_WB;
`else
                state_d = S_MEM;
`endif
            end
            S_MEM: begin
                if (!mem_class) begin
                    state_d = S_WB;
                end else begin
                    if (!mem_ready) wait_d = wait_q + 8'd1;
                    // A fault outranks a completion reported in the same cycle
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else if (mem_ready) begin
                        state_d = S_WB;
                    end else if (wait_q == WAIT_LAST) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end
                end
            end
            S_WB: state_d = S_PCUPD;
            S_PCUPD: begin
                cnt_inc = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Retired count sticks at all-ones rather than wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers with immediate reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= 4'h0;
            cnt_q   <= '0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // Moore decodes of the state register
    always_comb begin
        fetch_en    = (state_q == S_FETCH);
        decode_en   = (state_q == S_DEC);
        exec_en     = (state_q == S_EXEC);
        cc_we       = (state_q == S_EXEC) && (icode_q == 4'h6);
        mem_en      = (state_q == S_MEM);
        wb_en       = (state_q == S_WB);
        pc_en       = (state_q == S_PCUPD);
        busy        = (state_q != S_IDLE) && (state_q != S_HALT);
        halted      = (state_q == S_HALT);
        stat        = stat_q;
        instr_count = cnt_q;
    end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl: directed scoreboard bench for seq_stage_ctrl.
// Small counter width exposes saturation; short timeout exposes ADR faults.
module tb_seq_stage_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] icode;
    logic       instr_valid;
    logic       imem_error;
    logic       mem_ready;
    logic       dmem_error;
    logic       fetch_en, decode_en, exec_en, cc_we;
    logic       mem_en, wb_en, pc_en;
    logic [1:0] stat;
    logic       busy, halted;
    logic [1:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] EN_0  = 7'b0000000;
    localparam logic [6:0] EN_F  = 7'b1000000;
    localparam logic [6:0] EN_D  = 7'b0100000;
    localparam logic [6:0] EN_X  = 7'b0010000;
    localparam logic [6:0] EN_CC = 7'b0001000;
    localparam logic [6:0] EN_M  = 7'b0000100;
    localparam logic [6:0] EN_W  = 7'b0000010;
    localparam logic [6:0] EN_P  = 7'b0000001;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];

    seq_stage_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .mem_ready(mem_ready), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .cc_we(cc_we), .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en),
        .stat(stat), .busy(busy), .halted(halted),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [10:0] obs();
        return {fetch_en, decode_en, exec_en, cc_we, mem_en, wb_en,
                pc_en, stat, busy, halted};
    endfunction

    task automatic push(input string tag, input logic [6:0] en,
                        input logic [1:0] st, input logic b,
                        input logic h);
        exp_t e;
        e.tag = tag;
        e.exp = {en, st, b, h};
        sb.push_back(e);
    endtask

    task automatic run_q();
        exp_t e;
        logic [10:0] o;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            o = obs();
            n_cmp++;
            assert (o === e.exp) else begin
                n_bad++;
                $error("FAIL %s: observed %b expected %b",
                       e.tag, o, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] x);
        n_cmp++;
        assert (o === x) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, x);
        end
    endtask

    task automatic busy_exp(input string tag, input logic [6:0] en);
        push(tag, en, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic halt_exp(input string tag, input logic [1:0] st);
        push(tag, EN_0, st, 1'b0, 1'b1);
    endtask

    // Stages after FETCH for a non-memory instruction, ending on next FETCH
    task automatic instr_seq(input string tag, input bit cc);
        busy_exp({tag, "_dec"}, EN_D);
        busy_exp({tag, "_exe"}, cc ? (EN_X | EN_CC) : EN_X);
`ifndef SEQ_SKIP_MEM_EN
        busy_exp({tag, "_mem"}, EN_M);
`endif
        busy_exp({tag, "_wb"}, EN_W);
        busy_exp({tag, "_pc"}, EN_P);
        busy_exp({tag, "_fetch"}, EN_F);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        start = 1'b0;
        icode = 4'h0;
        instr_valid = 1'b1;
        imem_error = 1'b0;
        mem_ready = 1'b0;
        dmem_error = 1'b0;
        @(negedge clk);
        push(tag, EN_0, 2'b00, 1'b0, 1'b0);
        run_q();
        chk({tag, "_cnt"}, 32'(instr_count), 32'd0);
        rst = 1'b0;
    endtask

    task automatic start_at(input string tag, input logic [3:0] ic);
        icode = ic;
        start = 1'b1;
        busy_exp(tag, EN_F);
        run_q();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        icode = 4'h0;
        instr_valid = 1'b1;
        imem_error = 1'b0;
        mem_ready = 1'b0;
        dmem_error = 1'b0;

        // OPq timing, then a non-OPq that must not write CCs
        do_reset("t1_rst");
        start_at("t1_f", 4'h6);
        instr_seq("t1_op", 1'b1);
        run_q();
        chk("t1_cnt", 32'(instr_count), 32'd1);
        icode = 4'h2;
        instr_seq("t1_rr", 1'b0);
        run_q();
        chk("t1_cnt2", 32'(instr_count), 32'd2);

        // Memory wait of 3 cycles then completion
        do_reset("t2_rst");
        start_at("t2_f", 4'h5);
        busy_exp("t2_dec", EN_D);
        busy_exp("t2_exe", EN_X);
        busy_exp("t2_m0", EN_M);
        busy_exp("t2_m1", EN_M);
        busy_exp("t2_m2", EN_M);
        run_q();
        busy_exp("t2_m3", EN_M);
        run_q();
        mem_ready = 1'b1;
        busy_exp("t2_wb", EN_W);
        run_q();
        mem_ready = 1'b0;
        busy_exp("t2_pc", EN_P);
        busy_exp("t2_fetch", EN_F);
        run_q();
        chk("t2_cnt", 32'(instr_count), 32'd1);

        // Two nops then halt; start afterwards is ignored
        do_reset("t3_rst");
        start_at("t3_f", 4'h1);
        instr_seq("t3_i1", 1'b0);
        instr_seq("t3_i2", 1'b0);
        run_q();
        icode = 4'h0;
        halt_exp("t3_halt", 2'b01);
        run_q();
        chk("t3_cnt", 32'(instr_count), 32'd3);
        start = 1'b1;
        halt_exp("t3_st0", 2'b01);
        halt_exp("t3_st1", 2'b01);
        run_q();
        start = 1'b0;

        // Illegal icode, invalid fetch, and instruction address fault
        do_reset("t4_rst");
        start_at("t4_f", 4'hC);
        halt_exp("t4_ins", 2'b11);
        halt_exp("t4_ins2", 2'b11);
        run_q();
        chk("t4_cnt", 32'(instr_count), 32'd0);
        do_reset("t4b_rst");
        instr_valid = 1'b0;
        start_at("t4b_f", 4'h3);
        halt_exp("t4b_ins", 2'b11);
        run_q();
        do_reset("t4c_rst");
        imem_error = 1'b1;
        start_at("t4c_f", 4'h1);
        halt_exp("t4c_adr", 2'b10);
        run_q();

        // Memory timeout after exactly 4 waiting cycles
        do_reset("t5_rst");
        start_at("t5_f", 4'h8);
        busy_exp("t5_dec", EN_D);
        busy_exp("t5_exe", EN_X);
        busy_exp("t5_m0", EN_M);
        busy_exp("t5_m1", EN_M);
        busy_exp("t5_m2", EN_M);
        busy_exp("t5_m3", EN_M);
        halt_exp("t5_adr", 2'b10);
        halt_exp("t5_adr2", 2'b10);
        run_q();
        chk("t5_cnt", 32'(instr_count), 32'd0);

        // Error beats a simultaneous ready
        do_reset("t5b_rst");
        start_at("t5b_f", 4'h9);
        busy_exp("t5b_dec", EN_D);
        busy_exp("t5b_exe", EN_X);
        busy_exp("t5b_m0", EN_M);
        run_q();
        mem_ready = 1'b1;
        dmem_error = 1'b1;
        halt_exp("t5b_adr", 2'b10);
        run_q();
        mem_ready = 1'b0;
        dmem_error = 1'b0;

        // Asynchronous reset in the middle of a memory wait
        do_reset("t6_rst");
        start_at("t6_f", 4'h1);
        instr_seq("t6_i1", 1'b0);
        run_q();
        icode = 4'h4;
        busy_exp("t6_dec", EN_D);
        busy_exp("t6_exe", EN_X);
        busy_exp("t6_m0", EN_M);
        busy_exp("t6_m1", EN_M);
        run_q();
        #2 rst = 1'b1;
        #1;
        chk("t6_async", 32'(obs()), 32'd0);
        chk("t6_async_cnt", 32'(instr_count), 32'd0);
        do_reset("t6_rst2");
        start_at("t6_rf", 4'h1);
        instr_seq("t6_r", 1'b0);
        run_q();
        chk("t6_cnt", 32'(instr_count), 32'd1);

        // Counter saturation with a 2-bit count
        do_reset("t7_rst");
        start_at("t7_f", 4'h1);
        for (int i = 0; i < 4; i++) instr_seq("t7_i", 1'b0);
        run_q();
        chk("t7_sat", 32'(instr_count), 32'd3);
        icode = 4'h0;
        halt_exp("t7_halt", 2'b01);
        run_q();
        chk("t7_sat2", 32'(instr_count), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
Multi-cycle sequencer for the SEQ processor. Steps one instruction at a time through the fetch, decode, execute, memory, writeback and PC-update stages, issuing one stage enable per cycle. Gates condition-code writes from the execute ALU and handshakes with data memory. Tracks processor status (AOK/HLT/ADR/INS) and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter
MEM_TIMEOUT, 16, max consecutive MEMORY cycles without mem_ready before ADR fault (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin execution; sampled in IDLE only
icode  input  4  instruction code from fetch logic; sampled in FETCH
instr_valid  input  1  fetch logic has a decodable instruction
imem_error  input  1  instruction address fault; sampled in FETCH
mem_ready  input  1  data memory access complete
dmem_error  input  1  data memory address fault; sampled in MEMORY
fetch_en  output  1  fetch stage enable
decode_en  output  1  decode/register-read enable
exec_en  output  1  execute stage enable
cc_we  output  1  condition-code register write enable
mem_en  output  1  data memory request; held until the access completes
wb_en  output  1  register file write enable
pc_en  output  1  PC register update enable
stat  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS
busy  output  1  sequencer is running an instruction
halted  output  1  terminal state reached
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Stage enables and busy are Moore decodes of the state register; halted = (state==HALT).
- Reset (async, immediate, including mid-instruction): state=IDLE, all enables 0, stat=00, busy=0, halted=0, instr_count=0, latched icode=0, wait counter=0.
- IDLE: start=1 -> FETCH on the next edge; otherwise stay.
- start is ignored outside IDLE.
- FETCH: fetch_en=1; icode is latched on exit.
  - Priority: imem_error -> stat=ADR, HALT.
  - Else !instr_valid or icode>4'hB -> stat=INS, HALT.
  - Else icode==0 (halt) -> stat=HLT, instr_count+1, HALT.
  - Else -> DECODE.
- DECODE -> EXECUTE after 1 cycle.
- EXECUTE: exec_en=1; cc_we=1 only when latched icode==6 (OPq); EXECUTE -> MEMORY.
- MEMORY, memory-class icodes (4,5,8,9,A,B):
  - mem_en held high; wait counter increments each cycle mem_ready=0.
  - dmem_error=1 -> stat=ADR, HALT; error wins over a simultaneous mem_ready.
  - Else mem_ready=1 -> WRITEBACK.
  - Else if the MEM_TIMEOUT-th consecutive cycle ends without mem_ready -> stat=ADR, HALT.
  - Wait counter clears on MEMORY entry.
- MEMORY, other icodes: mem_en=1 for exactly 1 cycle; mem_ready and dmem_error ignored; -> WRITEBACK.
- WRITEBACK: wb_en=1 -> PCUPD.
- PCUPD: pc_en=1; instr_count+1; -> FETCH.
- instr_count saturates at all-ones.
- HALT: all enables 0, busy=0, stat frozen; exit only via rst.
- Faulted instructions are not counted and never assert wb_en or pc_en.
- Latency: start sampled at edge 0 -> fetch_en in cycle 1.
  - Non-memory instruction: 6 cycles FETCH to FETCH.
  - Memory instruction: 6 + wait cycles.
- Only one stage enable is high in any cycle.

Optional Feature:
SEQ_SKIP_MEM_EN:
- Defined: non-memory-class icodes go EXECUTE -> WRITEBACK directly, 5 cycles per instruction; mem_en is never asserted for them.
- Undefined: every instruction passes through MEMORY as described above.
- Memory-class behaviour is identical in both builds.

Test Plan:
1. Reset, start=1 for 1 cycle, icode=6 valid -> fetch_en cycle 1, decode_en cycle 2, exec_en+cc_we cycle 3, mem_en cycle 4, wb_en cycle 5, pc_en cycle 6, fetch_en cycle 7, instr_count=1; icode=2 run -> cc_we never high.
2. icode=5, mem_ready low for 3 MEMORY cycles then high -> mem_en high 4 cycles, then wb_en, pc_en; stat=00, instr_count=1.
3. icode=0 after two icode=1 instructions -> stat=01, halted=1, busy=0, instr_count=3; start pulse afterwards -> no enable asserted.
4. icode=4'hC (or instr_valid=0) -> stat=11, HALT the cycle after FETCH, instr_count unchanged, no wb_en/pc_en.
5. MEM_TIMEOUT=4, icode=8, mem_ready never -> mem_en high exactly 4 cycles, then stat=10, halted=1; separate run with dmem_error=mem_ready=1 in the same cycle -> stat=10.
6. rst pulsed during MEMORY wait -> all outputs 0 and stat=00 immediately, before the next clk edge; restart with start runs normally.
